// File: rtl/rx_symbol_sampler.sv
// 4x oversampled RX symbol sampler: decimates one sample per symbol at a selectable phase,
// with single-symbol late (5-sample) and early (3-sample) timing slips.
module rx_symbol_sampler #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [DATA_W-1:0] i_data,
    input  logic [1:0]        i_phase,
    input  logic              i_slip_late,
    input  logic              i_slip_early,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic [1:0]        o_counter,
    output logic              o_symbol_start,
    output logic              o_slip_busy
);

    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        phase_q, phase_d;
    logic              hold_q, hold_d;
    logic              late_q, late_d;
    logic              early_q, early_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              sos_q, sos_d;
    logic              applyLate;
    logic              boundary;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            cnt_q   <= 2'd0;
            phase_q <= i_phase;
            hold_q  <= 1'b0;
            late_q  <= 1'b0;
            early_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sos_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            hold_q  <= hold_d;
            late_q  <= late_d;
            early_q <= early_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sos_q   <= sos_d;
        end
    end

    // A symbol ends on an enabled index-3 sample unless that sample starts a late-slip hold;
    // the hold sample itself is the real end of a lengthened symbol.
    always_comb begin
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        hold_d    = hold_q;
        late_d    = late_q;
        early_d   = early_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        sos_d     = 1'b0;
        applyLate = i_enable && (cnt_q == 2'd3) && !hold_q && late_q;
        boundary  = i_enable && (cnt_q == 2'd3) && !applyLate;

        if (i_enable) begin
            if ((cnt_q == phase_q) && !hold_q) begin
                data_d  = i_data;
                valid_d = 1'b1;
            end
            if (applyLate) begin
                hold_d = 1'b1;
                late_d = 1'b0;
            end else if (boundary) begin
                hold_d  = 1'b0;
                sos_d   = 1'b1;
                phase_d = i_phase;
                if (early_q) begin
                    cnt_d   = 2'd1;
                    early_d = 1'b0;
                end else begin
                    cnt_d = 2'd0;
                end
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end

        // Only applied slips can clear busy, so acceptance never collides with a clear.
        if (!o_slip_busy && (i_slip_late ^ i_slip_early)) begin
            late_d  = i_slip_late;
            early_d = i_slip_early;
        end
    end

    assign o_data         = data_q;
    assign o_valid        = valid_q;
    assign o_counter      = cnt_q;
    assign o_symbol_start = sos_q;
    assign o_slip_busy    = late_q | early_q;

endmodule

// File: tb/tb_rx_symbol_sampler.sv
// Self-checking bench for rx_symbol_sampler: directed slip/phase/reset scenarios plus random
// traffic, compared against a symbol-level reference model built from per-symbol index lists.
module tb_rx_symbol_sampler;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              iReset;
    logic              iEnable;
    logic [DATA_W-1:0] iData;
    logic [1:0]        iPhase;
    logic              iSlipLate;
    logic              iSlipEarly;
    logic [DATA_W-1:0] oData;
    logic              oValid;
    logic [1:0]        oCounter;
    logic              oSymbolStart;
    logic              oSlipBusy;

    int total = 0;
    int bad = 0;

    // Remaining sample indices of the current symbol; 4 stands for the index-3 hold sample.
    int              symQ[$];
    int              actPhase;
    bit              pendLate;
    bit              pendEarly;
    logic [DATA_W-1:0] expData;
    bit              expValid;
    bit              expSos;

    always #5 clk = ~clk;

    rx_symbol_sampler #(.DATA_W(DATA_W)) dut (
        .clk           (clk),
        .i_reset       (iReset),
        .i_enable      (iEnable),
        .i_data        (iData),
        .i_phase       (iPhase),
        .i_slip_late   (iSlipLate),
        .i_slip_early  (iSlipEarly),
        .o_data        (oData),
        .o_valid       (oValid),
        .o_counter     (oCounter),
        .o_symbol_start(oSymbolStart),
        .o_slip_busy   (oSlipBusy)
    );

    function automatic int expCounter();
        return (symQ[0] == 4) ? 3 : symQ[0];
    endfunction

    task automatic modelStep(input bit rst, input bit en, input logic [DATA_W-1:0] d,
                             input logic [1:0] ph, input bit late, input bit early);
        bit busyBefore;
        int cur;
        busyBefore = pendLate | pendEarly;
        if (rst) begin
            symQ      = '{0, 1, 2, 3};
            actPhase  = int'(ph);
            expData   = '0;
            expValid  = 1'b0;
            expSos    = 1'b0;
            pendLate  = 1'b0;
            pendEarly = 1'b0;
        end else begin
            expValid = 1'b0;
            expSos   = 1'b0;
            if (en) begin
                cur = symQ.pop_front();
                if (cur == actPhase) begin
                    expData  = d;
                    expValid = 1'b1;
                end
                if (symQ.size() == 0) begin
                    if (cur == 3 && pendLate) begin
                        symQ.push_back(4);
                        pendLate = 1'b0;
                    end else begin
                        expSos   = 1'b1;
                        actPhase = int'(ph);
                        if (pendEarly) begin
                            symQ      = '{1, 2, 3};
                            pendEarly = 1'b0;
                        end else begin
                            symQ = '{0, 1, 2, 3};
                        end
                    end
                end
            end
            if (!busyBefore && (late != early)) begin
                pendLate  = late;
                pendEarly = early;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit en, input logic [DATA_W-1:0] d,
                                 input logic [1:0] ph, input bit late, input bit early);
        iReset     = rst;
        iEnable    = en;
        iData      = d;
        iPhase     = ph;
        iSlipLate  = late;
        iSlipEarly = early;
        modelStep(rst, en, d, ph, late, early);
        @(posedge clk);
        #1;
        checkOutput("counter", 32'(oCounter), 32'(expCounter()));
        checkOutput("valid", 32'(oValid), 32'(expValid));
        checkOutput("data", 32'(oData), 32'(expData));
        checkOutput("symStart", 32'(oSymbolStart), 32'(expSos));
        checkOutput("slipBusy", 32'(oSlipBusy), 32'(pendLate | pendEarly));
    endtask

    initial begin
        int  rampVal;
        bit  reached;
        iReset     = 1'b1;
        iEnable    = 1'b0;
        iData      = '0;
        iPhase     = 2'd0;
        iSlipLate  = 1'b0;
        iSlipEarly = 1'b0;
        @(posedge clk);
        #1;

        // Reset, then a continuous ramp at phase 2
        applyStimulus(1, 0, 8'd0, 2'd2, 0, 0);
        applyStimulus(1, 0, 8'd0, 2'd2, 0, 0);
        for (int i = 0; i < 16; i++) applyStimulus(0, 1, 8'(i), 2'd2, 0, 0);
        checkOutput("rampLast", 32'(oData), 32'd14);

        // Phase 2 -> 0 requested at index 1; takes effect on the next symbol
        rampVal = 16;
        applyStimulus(0, 1, 8'(rampVal), 2'd2, 0, 0);
        rampVal++;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(0, 1, 8'(rampVal), 2'd0, 0, 0);
            rampVal++;
        end

        // Late slip at phase 3
        applyStimulus(0, 1, 8'(rampVal), 2'd3, 1, 0);
        rampVal++;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 8'(rampVal), 2'd3, 0, 0);
            rampVal++;
        end

        // Early slip at phase 0
        applyStimulus(0, 1, 8'(rampVal), 2'd0, 0, 1);
        rampVal++;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 8'(rampVal), 2'd0, 0, 0);
            rampVal++;
        end

        // Both slips together are ignored; a repeat request while busy is ignored
        applyStimulus(0, 1, 8'(rampVal), 2'd1, 1, 1);
        checkOutput("bothIgnored", 32'(oSlipBusy), 32'd0);
        applyStimulus(0, 1, 8'(rampVal + 1), 2'd1, 1, 0);
        applyStimulus(0, 1, 8'(rampVal + 2), 2'd1, 1, 0);
        for (int i = 0; i < 12; i++) applyStimulus(0, 1, 8'(rampVal + 3 + i), 2'd1, 0, 0);

        // Enable toggling, late slip, reset landing on the hold sample
        reached = 1'b0;
        applyStimulus(0, 1, 8'h40, 2'd1, 1, 0);
        for (int i = 0; i < 30 && !reached; i++) begin
            applyStimulus(0, (i % 2) == 0, 8'(8'h41 + i), 2'd1, 0, 0);
            if (symQ[0] == 4) reached = 1'b1;
        end
        checkOutput("holdReached", 32'(reached), 32'd1);
        applyStimulus(1, 1, 8'h77, 2'd0, 1, 0);
        checkOutput("rstCounter", 32'(oCounter), 32'd0);
        checkOutput("rstValid", 32'(oValid), 32'd0);
        checkOutput("rstData", 32'(oData), 32'd0);
        for (int i = 0; i < 6; i++) applyStimulus(0, (i % 2) == 0, 8'(i), 2'd0, 0, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 3) != 0,
                          8'($urandom),
                          2'($urandom_range(0, 3)),
                          $urandom_range(0, 15) == 0,
                          $urandom_range(0, 15) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_symbol_sampler.md
RX_SYMBOL_SAMPLER -- requirements
Module: rx_symbol_sampler

Interface
REQ-001 Parameter: DATA_W, 8, sample width in bits, two's complement.
REQ-002 Parameter: OS is fixed at 4 samples per symbol and is not a parameter.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 i_reset  input  1  reset, synchronous, active-high.
REQ-005 i_enable  input  1  sample strobe; i_data is valid this cycle, at most one sample per clk.
REQ-006 i_data  input  DATA_W  oversampled RX sample.
REQ-007 i_phase  input  2  requested sampling phase, 0..3.
REQ-008 i_slip_late  input  1  one-cycle request to lengthen the next symbol to 5 samples.
REQ-009 i_slip_early  input  1  one-cycle request to shorten the next symbol to 3 samples.
REQ-010 o_data  output  DATA_W  decimated symbol sample.
REQ-011 o_valid  output  1  one-cycle qualifier for o_data.
REQ-012 o_counter  output  2  current intra-symbol sample index.
REQ-013 o_symbol_start  output  1  one-cycle pulse marking the first sample of a symbol.
REQ-014 o_slip_busy  output  1  a slip is pending and not yet applied.

Function
REQ-015 The counter SHALL change only on cycles with i_enable=1; all outputs except o_slip_busy SHALL hold when i_enable=0, and o_valid and o_symbol_start SHALL be 0 on those cycles.
REQ-016 With no slip pending, the counter SHALL advance 0->1->2->3->0 on each enabled sample.
REQ-017 The active phase register SHALL load i_phase only on the enabled sample where counter==3, so a phase change takes effect from the next symbol and never mid-symbol.
REQ-018 On an enabled sample with counter==active phase and not in a hold sample, o_data SHALL be loaded with i_data and o_valid SHALL be 1 on the following cycle. Latency is 1 clk.
REQ-019 o_symbol_start SHALL be 1 on the cycle after the enabled sample that leaves counter at 0. After an early slip, this is the sample that leaves counter at 1.
REQ-020 A slip request with o_slip_busy=0 SHALL set o_slip_busy on the next cycle.
REQ-021 A slip request while o_slip_busy=1 SHALL be ignored.
REQ-022 i_slip_late and i_slip_early asserted together SHALL both be ignored.
REQ-023 Pending late slip, applied at the enabled sample where counter==3:
- The counter SHALL stay at 3 for one additional enabled sample (the hold sample), then wrap to 0.
- No capture SHALL occur on the hold sample.
REQ-024 Pending early slip, applied at the enabled sample where counter==3:
- The counter SHALL go to 1, skipping 0.
- If the active phase is 0, that symbol SHALL produce no o_valid.
- o_symbol_start SHALL still pulse once for that symbol.
REQ-025 o_slip_busy SHALL clear on the cycle after the slip is applied. A new request is accepted on that same clear cycle.
REQ-026 Exactly zero or one o_valid pulse SHALL occur per symbol under all slip and phase combinations.

Reset
REQ-027 On i_reset=1 at a clk edge, the block SHALL set:
- counter=0
- active phase=i_phase
- o_data=0
- o_valid=0
- o_symbol_start=0
- o_slip_busy=0
- hold flag cleared
- all pending slips discarded
REQ-028 Reset SHALL take priority over i_enable and slip inputs, including mid-symbol and mid-hold.
REQ-029 The first enabled sample after reset SHALL be counter index 0. It produces o_symbol_start only from the following symbol boundary; no pulse is issued for the reset-entry symbol.

Verification
REQ-030 Continuous enable, i_phase=2, data ramp 0,1,2,...: o_valid every 4 clks with o_data=2,6,10,...; o_counter cycles 0..3.
REQ-031 i_phase changed 2->0 while counter==1: the current symbol still captures phase 2, and the next symbol captures phase 0.
REQ-032 i_slip_late pulse with i_phase=3: o_slip_busy high until the boundary; o_counter shows 3,3 across two enabled samples; only one o_valid for that symbol; next symbol_start arrives 5 samples after the previous one.
REQ-033 i_slip_early with i_phase=0: o_counter goes 3->1; no o_valid for that symbol; o_symbol_start still pulses; the following symbol captures normally.
REQ-034 Both slips asserted together, then i_slip_late while busy: the first pair is ignored (o_slip_busy stays 0); a later second request during busy does not extend the slip.
REQ-035 i_enable toggling 1,0,1,0 plus i_reset asserted during a late-slip hold: the counter advances only on enabled cycles; after reset all outputs are 0 and counter=0.
